// File: rtl/xillybus_loop_fifo_pkg.sv
// Shared types and defaults for the Xillybus loopback FIFO endpoint.
// Session states and default geometry live here so the interface, RAM and top agree.
package xillybus_loop_fifo_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH_LOG2 = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        EOF    = 2'd3
    } state_t;

endpackage

// File: rtl/xillybus_loop_fifo_if.sv
// Host-write / host-read stream signals between the Xillybus core and the loopback FIFO.
// The master modport is the core side; the slave modport is the FIFO endpoint.
interface xillybus_loop_fifo_if #(
    parameter int WIDTH      = xillybus_loop_fifo_pkg::DEF_WIDTH,
    parameter int DEPTH_LOG2 = xillybus_loop_fifo_pkg::DEF_DEPTH_LOG2
);
    logic                  user_w_wr_wren;
    logic [WIDTH-1:0]      user_w_wr_data;
    logic                  user_w_wr_open;
    logic                  user_w_wr_full;
    logic                  user_r_rd_rden;
    logic                  user_r_rd_open;
    logic [WIDTH-1:0]      user_r_rd_data;
    logic                  user_r_rd_empty;
    logic                  user_r_rd_eof;
    logic [DEPTH_LOG2:0]   fill_count;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output user_w_wr_wren, user_w_wr_data, user_w_wr_open,
        output user_r_rd_rden, user_r_rd_open,
        input  user_w_wr_full, user_r_rd_data, user_r_rd_empty, user_r_rd_eof,
        input  fill_count, overflow_err, underflow_err
    );

    modport slave (
        input  user_w_wr_wren, user_w_wr_data, user_w_wr_open,
        input  user_r_rd_rden, user_r_rd_open,
        output user_w_wr_full, user_r_rd_data, user_r_rd_empty, user_r_rd_eof,
        output fill_count, overflow_err, underflow_err
    );
endinterface

// File: rtl/xillybus_loop_fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with read enable.
// Only the output register is reset so the array still maps onto block RAM.
module xillybus_sdp_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]  i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [WIDTH-1:0]  o_rdData
);
    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdData <= '0;
        end else if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end
endmodule

// File: rtl/xillybus_loop_fifo.sv
// Loopback FIFO endpoint: buffers host-write words and replays them on the host-read stream,
// with a file-style session that signals EOF once the writer has closed and the buffer drained.
module xillybus_loop_fifo
    import xillybus_loop_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int WIDTH      = DEF_WIDTH
) (
    input  logic                 bus_clk,
    input  logic                 rst,
    xillybus_loop_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

    logic [DEPTH_LOG2-1:0] r_wPtr;
    logic [DEPTH_LOG2-1:0] r_rPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_countNext;
    logic                  r_wrOpen;
    logic                  r_rdOpen;
    logic                  r_overflow;
    logic                  r_underflow;
    state_t                r_state;
    state_t                w_stateNext;

    logic w_full;
    logic w_empty;
    logic w_flush;
    logic w_wrAcc;
    logic w_rdAcc;
    logic w_wrRise;
    logic w_wrFall;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_empty  = (r_count == '0) || (r_state == EOF);
    assign w_flush  = r_rdOpen && !bus.user_r_rd_open;
    assign w_wrRise = bus.user_w_wr_open && !r_wrOpen;
    assign w_wrFall = !bus.user_w_wr_open && r_wrOpen;
    // A write landing in the flush cycle is dropped silently, not counted as overflow.
    assign w_wrAcc  = bus.user_w_wr_wren && !w_full && !w_flush;
    assign w_rdAcc  = bus.user_r_rd_rden && !w_empty;

    assign w_countNext = r_count + (DEPTH_LOG2+1)'(w_wrAcc) - (DEPTH_LOG2+1)'(w_rdAcc);

    xillybus_sdp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk      (bus_clk),
        .rst      (rst),
        .i_wrEn   (w_wrAcc),
        .i_wrAddr (r_wPtr),
        .i_wrData (bus.user_w_wr_data),
        .i_rdEn   (w_rdAcc),
        .i_rdAddr (r_rPtr),
        .o_rdData (bus.user_r_rd_data)
    );

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_wPtr      <= '0;
            r_rPtr      <= '0;
            r_count     <= '0;
            r_wrOpen    <= 1'b0;
            r_rdOpen    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= IDLE;
        end else begin
            r_wrOpen <= bus.user_w_wr_open;
            r_rdOpen <= bus.user_r_rd_open;
            r_state  <= w_stateNext;
            if (w_flush) begin
                r_wPtr  <= '0;
                r_rPtr  <= '0;
                r_count <= '0;
            end else begin
                if (w_wrAcc) r_wPtr <= r_wPtr + 1'b1;
                if (w_rdAcc) r_rPtr <= r_rPtr + 1'b1;
                r_count <= w_countNext;
            end
            if (bus.user_w_wr_wren && w_full && !w_flush) r_overflow <= 1'b1;
            if (bus.user_r_rd_rden && w_empty) r_underflow <= 1'b1;
        end
    end

    // EOF decisions look at the post-edge count so eof rises together with the last pop.
    always_comb begin
        w_stateNext = r_state;
        if (w_flush) begin
            w_stateNext = bus.user_w_wr_open ? STREAM : IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_wrRise) w_stateNext = STREAM;
                STREAM:  if (w_wrFall) w_stateNext = (w_countNext == '0) ? EOF : DRAIN;
                DRAIN:   if (w_countNext == '0) w_stateNext = EOF;
                EOF:     if (w_wrRise) w_stateNext = STREAM;
                default: w_stateNext = IDLE;
            endcase
        end
    end

    assign bus.user_w_wr_full  = w_full;
    assign bus.user_r_rd_empty = w_empty;
    assign bus.user_r_rd_eof   = (r_state == EOF);
    assign bus.fill_count      = r_count;
    assign bus.overflow_err    = r_overflow;
    assign bus.underflow_err   = r_underflow;
endmodule
